// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding onto the ALU inputs.
// Also flags load-use hazards to the upstream stall logic and supports hold and bubble insertion.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic        id_alusrc1,
    input  logic        id_alusrc2,
    input  logic [5:0]  id_alufun,
    input  logic        id_sign,
    input  logic [4:0]  id_dst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_dst,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_dst,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [4:0]  ex_dst,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_store_data,
    output logic        load_use
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        alusrc1;
        logic        alusrc2;
        logic [5:0]  alufun;
        logic        sign;
        logic [4:0]  dst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } ex_reg_t;

    ex_reg_t     ex_q, ex_d, id_fields;
    logic [31:0] fwd_rs, fwd_rt;

    // EX/MEM is the younger producer, so it takes precedence; $0 is hardwired and never forwarded.
    function automatic logic [31:0] forward(input logic [4:0] addr, input logic [31:0] reg_data,
                                            input logic em_we, input logic [4:0] em_dst,
                                            input logic [31:0] em_res, input logic mw_we,
                                            input logic [4:0] mw_dst, input logic [31:0] mw_res);
        if (em_we && em_dst == addr && addr != 5'd0)
            return em_res;
        else if (mw_we && mw_dst == addr && addr != 5'd0)
            return mw_res;
        else
            return reg_data;
    endfunction

    always_comb begin
        fwd_rs = forward(ex_q.rs_addr, ex_q.rs_data, exmem_regwrite, exmem_dst, exmem_result,
                         memwb_regwrite, memwb_dst, memwb_result);
        fwd_rt = forward(ex_q.rt_addr, ex_q.rt_data, exmem_regwrite, exmem_dst, exmem_result,
                         memwb_regwrite, memwb_dst, memwb_result);
    end

    assign load_use = ex_q.valid & ex_q.memread & (ex_q.dst != 5'd0) &
                      ((ex_q.dst == id_rs_addr) | (ex_q.dst == id_rt_addr));

    always_comb begin
        id_fields = '{valid: id_valid, pc: id_pc, rs_addr: id_rs_addr, rt_addr: id_rt_addr,
                      rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm, shamt: id_shamt,
                      alusrc1: id_alusrc1, alusrc2: id_alusrc2, alufun: id_alufun,
                      sign: id_sign, dst: id_dst, regwrite: id_regwrite,
                      memread: id_memread, memwrite: id_memwrite};
        ex_d = id_fields;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            // Hold, but refresh operand data so a producer retiring during the stall is not lost.
            ex_d         = ex_q;
            ex_d.rs_data = fwd_rs;
            ex_d.rt_data = fwd_rt;
        end else if (load_use) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign alu_a         = ex_q.alusrc1 ? {27'b0, ex_q.shamt} : fwd_rs;
    assign alu_b         = ex_q.alusrc2 ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_fun       = ex_q.alufun;
    assign alu_sign      = ex_q.sign;
    assign ex_valid      = ex_q.valid;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_dst        = ex_q.dst;
    assign ex_pc         = ex_q.pc;

endmodule
